// File: rtl/pwm_ui_pkg.sv
// Shared types and helpers for the operator-input stage: setting widths,
// per-button FSM states and the edit-select encoding.
package pwm_ui_pkg;

  localparam int IF_W = 3;
  localparam int IC_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } btn_state_e;

  localparam logic SEL_FREQ = 1'b0;
  localparam logic SEL_CURR = 1'b1;

  // One step up or down, clamped to [0, max_v]; an up+down request is the caller's job.
  function automatic logic [7:0] sat_step(input logic [7:0] val,
                                          input logic [7:0] max_v,
                                          input logic       up,
                                          input logic       dn);
    logic [7:0] r;
    r = val;
    if (up && (val < max_v)) begin
      r = val + 8'd1;
    end else if (dn && (val != 8'd0)) begin
      r = val - 8'd1;
    end else begin
      r = val;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output level only
// follows the synced input after DEBOUNCE_CYCLES consecutive differing samples.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Counter restarts whenever the synced sample agrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/pwm_setting_ctrl.sv
// Operator-input stage: debounced up/down buttons with hold-to-repeat editing
// two saturating settings (frequency index iF, current index iC).
module pwm_setting_ctrl
  import pwm_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int IF_MAX          = 7,
  parameter int IF_RST          = 0,
  parameter int IC_MAX          = 15,
  parameter int IC_RST          = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            switch,
  output logic [IF_W-1:0] iF,
  output logic [IC_W-1:0] iC,
  output logic            cambio
);

  localparam int T_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW    = $clog2(T_MAX);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  logic [1:0]      lvl_s;
  logic            sel_s, sel_prev_q, toggle_s, both_s;
  btn_state_e      state_q [2];
  btn_state_e      state_d [2];
  logic [TW-1:0]   timer_q [2];
  logic [TW-1:0]   timer_d [2];
  logic [1:0]      step_q, step_d;
  logic            up_s, dn_s;
  logic [IF_W-1:0] if_q, if_d;
  logic [IC_W-1:0] ic_q, ic_d;
  logic            cambio_q, cambio_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clock_i(clock), .reset_i(reset), .raw_i(btn_up),   .level_o(lvl_s[0]));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clock_i(clock), .reset_i(reset), .raw_i(btn_down), .level_o(lvl_s[1]));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw (
    .clock_i(clock), .reset_i(reset), .raw_i(switch),   .level_o(sel_s));

  assign toggle_s = sel_s ^ sel_prev_q;
  assign both_s   = lvl_s[0] & lvl_s[1];

  // Index 0 = up button, 1 = down button; steps are suppressed while both are held.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      step_d[i]  = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (lvl_s[i]) begin
            state_d[i] = PRESS;
            timer_d[i] = '0;
            step_d[i]  = ~both_s;
          end else begin
            state_d[i] = IDLE;
          end
        end
        PRESS: begin
          if (!lvl_s[i]) begin
            state_d[i] = IDLE;
            timer_d[i] = '0;
          end else if (toggle_s) begin
            state_d[i] = LOCK;
            timer_d[i] = '0;
          end else if (timer_q[i] == HOLD_LAST) begin
            state_d[i] = REPEAT;
            timer_d[i] = '0;
            step_d[i]  = ~both_s;
          end else begin
            timer_d[i] = timer_q[i] + TW'(1);
          end
        end
        REPEAT: begin
          if (!lvl_s[i]) begin
            state_d[i] = IDLE;
            timer_d[i] = '0;
          end else if (toggle_s) begin
            state_d[i] = LOCK;
            timer_d[i] = '0;
          end else if (timer_q[i] == REP_LAST) begin
            timer_d[i] = '0;
            step_d[i]  = ~both_s;
          end else begin
            timer_d[i] = timer_q[i] + TW'(1);
          end
        end
        LOCK: begin
          if (!lvl_s[i]) begin
            state_d[i] = IDLE;
          end else begin
            state_d[i] = LOCK;
          end
        end
        default: begin
          state_d[i] = IDLE;
          timer_d[i] = '0;
        end
      endcase
    end
  end

  // Simultaneous up and down steps cancel; only the selected setting moves.
  always_comb begin
    up_s = step_q[0] & ~step_q[1];
    dn_s = step_q[1] & ~step_q[0];
    if_d = if_q;
    ic_d = ic_q;
    if (sel_s == SEL_FREQ) begin
      if_d = IF_W'(sat_step(8'(if_q), 8'(IF_MAX), up_s, dn_s));
    end else begin
      ic_d = IC_W'(sat_step(8'(ic_q), 8'(IC_MAX), up_s, dn_s));
    end
    cambio_d = (if_d != if_q) || (ic_d != ic_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
      step_q     <= 2'b00;
      sel_prev_q <= 1'b0;
      if_q       <= IF_W'(IF_RST);
      ic_q       <= IC_W'(IC_RST);
      cambio_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      step_q     <= step_d;
      sel_prev_q <= sel_s;
      if_q       <= if_d;
      ic_q       <= ic_d;
      cambio_q   <= cambio_d;
    end
  end

  assign iF     = if_q;
  assign iC     = ic_q;
  assign cambio = cambio_q;

endmodule
